// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types and modulo-N index helpers
package arb_pkg;

  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_e;

  // (base + off) mod n, for 0 <= base < n and 0 <= off < n; never wraps at 2^IdxW
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end
    return sum;
  endfunction

  // Successor of idx among n requesters, wrapping to 0 after n-1
  function automatic int wrap_inc(input int idx, input int n);
    return wrap_add(idx, (n > 1) ? 1 : 0, n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker starting at ptr
module rr_pick
  import arb_pkg::*;
#(
  parameter int Inputs = 4,
  parameter int IdxW   = (Inputs > 1) ? $clog2(Inputs) : 1
) (
  input  logic            req [Inputs],
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] cand;

  // Walk ptr, ptr+1, ... modulo Inputs and keep the first requester seen
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < Inputs; k++) begin
      cand = IdxW'(wrap_add(int'(ptr), k, Inputs));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with held grant over valid/ready
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int Inputs = 4,
  parameter int IdxW   = (Inputs > 1) ? $clog2(Inputs) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req     [Inputs],
  output logic            gnt     [Inputs],
  output logic [IdxW-1:0] gnt_idx,
  output logic            valid,
  input  logic            ready,
  output logic            ack     [Inputs]
);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] held_idx_q, held_idx_d;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] sel_idx;

  rr_pick #(
    .Inputs (Inputs),
    .IdxW   (IdxW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Grant outputs depend only on state and req; ready reaches nothing but ack
  always_comb begin
    sel_idx = (state_q == ARB_HELD) ? held_idx_q : pick_idx;
    valid   = (state_q == ARB_HELD) || pick_found;
    gnt_idx = valid ? sel_idx : '0;
    for (int i = 0; i < Inputs; i++) begin
      gnt[i] = valid && (sel_idx == IdxW'(i));
      ack[i] = valid && (sel_idx == IdxW'(i)) && ready;
    end
  end

  // Pointer moves only on a completed transfer; a stall latches the pick
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    held_idx_d = held_idx_q;
    case (state_q)
      ARB_FREE: begin
        if (pick_found) begin
          if (ready) begin
            ptr_d = IdxW'(wrap_inc(int'(pick_idx), Inputs));
          end else begin
            held_idx_d = pick_idx;
            state_d    = ARB_HELD;
          end
        end
      end
      ARB_HELD: begin
        if (ready) begin
          ptr_d   = IdxW'(wrap_inc(int'(held_idx_q), Inputs));
          state_d = ARB_FREE;
        end
      end
    endcase
  end

  // State registers; reset abandons any held grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_FREE;
      ptr_q      <= '0;
      held_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      held_idx_q <= held_idx_d;
    end
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that produces the one-hot select vector consumed by the one-hot AND-OR `mux` in the datapath. It chooses one of `Inputs` requesters with rotating priority and presents the grant to a downstream consumer over a valid/ready handshake. While the consumer stalls, the grant is held stable, so the mux output also stays stable for the whole transfer.

## Interface
Parameters:
- `Inputs`, default 4. Number of requesters; must be ≥ 1.
- `IdxW`, default `(Inputs > 1) ? $clog2(Inputs) : 1`. Width of `gnt_idx`; derived, never overridden.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `req[Inputs]`  in  1 each  Per-requester request. Unpacked array.
- `gnt[Inputs]`  out  1 each  One-hot (or all-zero) grant. Wires directly to `mux.sel`.
- `gnt_idx`  out  IdxW  Binary index of the granted requester; 0 when `valid` = 0.
- `valid`  out  1  A grant is being offered downstream.
- `ready`  in  1  Downstream accepts the current grant this cycle.
- `ack[Inputs]`  out  1 each  `gnt[i] & ready`: the transfer from requester i completes this cycle.

## Operation
- State: priority pointer `ptr` (IdxW), FSM `state` ∈ {FREE, HELD}, latched index `held_idx`.
- Pick function: find the first `i` with `req[i] = 1`, scanning `ptr, ptr+1, …, Inputs-1, 0, …, ptr-1`. Index arithmetic wraps modulo `Inputs`, not modulo 2^IdxW.
- FREE:
  - `gnt` = one-hot of the pick; `valid` = OR of `req`.
  - If `valid & ready`: `ptr <= pick+1` (wrapping to 0 after `Inputs-1`); stay in FREE.
  - If `valid & !ready`: `held_idx <= pick`; go to HELD.
  - If no `req`: all outputs 0; `ptr` unchanged.
- HELD:
  - `gnt` = one-hot of `held_idx`; `valid` = 1, regardless of `req`.
  - New or higher-priority requests do not change the grant.
  - On `ready`: `ptr <= held_idx+1` (wrapped); go to FREE.
- Requester protocol: a requester keeps `req` asserted until its `ack`. Dropping `req` early is a protocol violation. The arbiter still completes the held grant; the bench flags the violation with an assertion.
- Invariants:
  - `gnt` has at most one bit set.
  - `valid == |gnt`.
  - `ack` is a subset of `gnt`.
- `Inputs = 1`: `ptr` and `gnt_idx` are constant 0; `gnt[0] = req[0]` in FREE.

## Timing
- Reset values, applied on the clock edge where `rst` = 1: `ptr` = 0, `state` = FREE, `held_idx` = 0.
- Outputs are combinational from state and `req`. With `req` all zero during reset, every output is 0.
- Reset mid-transfer: the HELD grant is abandoned, no `ack` is issued, and the block is back in FREE with `ptr` = 0 on the next cycle.
- Latency:
  - `req` → `gnt`/`valid`: 0 cycles in FREE (combinational).
  - Transfer completes in the cycle where `valid & ready` is true.
  - Back-to-back grants to different requesters are possible every cycle.
- Priority updates only on a completed transfer. A stall (`ready` = 0) never moves `ptr`.
- No combinational path from `ready` to `gnt`, `gnt_idx` or `valid`. `ready` affects only `ack` and next-state logic.
- Fairness: with all requesters continuously requesting and `ready` = 1, each requester is granted exactly once per `Inputs` cycles.

## Structure
- Shared package `arb_pkg`: `typedef enum logic {ARB_FREE, ARB_HELD} arb_state_e;`.
- One sub-module, `rr_pick`: purely combinational. Inputs `req[Inputs]` and `ptr`; outputs `found` and `idx`.
  - Implemented as a double-length scan or a masked-then-unmasked priority encoder.
  - Reusable by other arbiters in the core.
- The `rr_arbiter` top holds `ptr`, the FSM, the `held_idx` register, and one-hot decode of the index into `gnt`.

## Test plan
- Reset and idle: hold `rst` = 1 for 2 cycles with `req` = 0000, then release. Expect `gnt` = 0000, `valid` = 0, `gnt_idx` = 0, `ack` = 0000.
- Rotation: `req` = 1111, `ready` = 1 for 8 cycles. Expect `gnt_idx` sequence 0,1,2,3,0,1,2,3 and exactly one `ack` bit per cycle.
- Stall hold: from reset, `req` = 0100, `ready` = 0 for 3 cycles, and `req[0]` also rises in cycle 2.
  - Expect `gnt` to stay on index 2 for all 3 cycles.
  - Then `ready` = 1: `ack[2]` = 1.
  - Next cycle, `gnt_idx` = 0 (`ptr` = 3 wraps to index 0 because `req[3]` = 0).
- Skip and wrap: `ptr` = 3 (reached after granting index 2), `req` = 1010, `ready` = 1. Expect grant 3, then 1, then 3 — index 0 is never granted.
- Reset mid-HELD: enter HELD on index 1, then assert `rst` for 1 cycle. Expect no `ack[1]`, and afterwards `state` = FREE, `ptr` = 0; with `req` = 1111, `gnt_idx` = 0.
- Mux integration: drive `gnt` into `mux` with `in` = {0x11, 0x22, 0x33, 0x44} and `req` = 1001, `ready` = 1. Expect `out` to alternate 0x11, 0x44, 0x11, … and never any OR of two inputs.
